// File: rtl/qmax_table_rmw_if.sv
// -----------------------------------------------------------------------------
// qmax_table_rmw_if
// Port bundle for the Q-max table: clear/busy control, read port and
// overwrite/max-update write port.
//   master : drives the requests (i_*) and observes the responses (o_*)
//   slave  : the table itself
// -----------------------------------------------------------------------------
interface qmax_table_rmw_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  i_clear;
  logic                  o_busy;
  logic                  i_rd_en;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic                  o_rd_valid;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  i_wr_en;
  logic                  i_wr_mode;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_updated;

  modport master (
    output i_clear, i_rd_en, i_rd_addr, i_wr_en, i_wr_mode, i_wr_addr, i_wr_data,
    input  o_busy, o_rd_valid, o_rd_data, o_updated
  );

  modport slave (
    input  i_clear, i_rd_en, i_rd_addr, i_wr_en, i_wr_mode, i_wr_addr, i_wr_data,
    output o_busy, o_rd_valid, o_rd_data, o_updated
  );
endinterface

// File: rtl/qmax_table_rmw.sv
// -----------------------------------------------------------------------------
// qmax_table_rmw
// One max-Q value per state. 1-cycle read port, pipelined write port with
// overwrite or max-update (read-modify-write, commits only on a larger value),
// and a self-timed sequential clear after reset or on request.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   io_bus   : qmax_table_rmw_if.slave (clear/busy, read port, write port,
//              o_updated pulse)
// -----------------------------------------------------------------------------
module qmax_table_rmw #(
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           DEPTH      = 64,
  parameter bit                    SIGNED     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  qmax_table_rmw_if.slave    io_bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Stage S1: write accepted in the previous cycle, with its captured old value
  logic                  r_s1_valid;
  logic                  r_s1_mode;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [DATA_WIDTH-1:0] r_s1_old;

  logic                  r_busy;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_updated;

  logic                  w_run;
  logic                  w_port_en;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_s1_gt;
  logic                  w_s1_commit;
  logic                  w_s1_changed;
  logic [DATA_WIDTH-1:0] w_s1_eff;
  logic [DATA_WIDTH-1:0] w_wr_old;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // Request qualification: ports are live only in RUN and not on a clear request
  assign w_run         = (r_state == ST_RUN);
  assign w_port_en     = w_run && !io_bus.i_clear;
  assign w_wr_in_range = (32'(io_bus.i_wr_addr) < DEPTH);
  assign w_rd_in_range = (32'(io_bus.i_rd_addr) < DEPTH);
  assign w_wr_acc      = w_port_en && io_bus.i_wr_en && w_wr_in_range;
  assign w_rd_acc      = w_port_en && io_bus.i_rd_en;

  // S1 resolve: compare selects signed or unsigned ordering
  assign w_s1_gt      = SIGNED ? ($signed(r_s1_data) > $signed(r_s1_old))
                               : (r_s1_data > r_s1_old);
  assign w_s1_commit  = r_s1_valid && (!r_s1_mode || w_s1_gt);
  assign w_s1_eff     = w_s1_commit ? r_s1_data : r_s1_old;
  assign w_s1_changed = w_s1_commit && (r_s1_data != r_s1_old);

  // Old value for a new write and read data both forward the S1 result on an
  // address match, since memory is only updated at the end of the S1 cycle
  assign w_wr_old = (r_s1_valid && (r_s1_addr == io_bus.i_wr_addr))
                    ? w_s1_eff : r_mem[io_bus.i_wr_addr];

  always_comb begin
    w_rd_val = INIT_VAL;
    if (w_rd_in_range) begin
      if (r_s1_valid && (r_s1_addr == io_bus.i_rd_addr)) begin
        w_rd_val = w_s1_eff;
      end else begin
        w_rd_val = r_mem[io_bus.i_rd_addr];
      end
    end
  end

  // Single memory write port: clear sweep in CLEAR, S1 commit in RUN
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_s1_addr;
    w_mem_wdata = r_s1_data;
    if (r_state == ST_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_cnt;
      w_mem_wdata = INIT_VAL;
    end else if (w_port_en && w_s1_commit) begin
      w_mem_we = 1'b1;
    end
  end

  // Storage array, no reset: the clear sweep initialises it
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Control FSM, S1 stage and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_busy     <= 1'b1;
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
      r_s1_old   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_updated  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_val;
      end

      // A clear request drops the pending S1 write, so no pulse either
      r_updated  <= w_port_en && w_s1_changed;
      r_s1_valid <= w_wr_acc;
      if (w_wr_acc) begin
        r_s1_mode <= io_bus.i_wr_mode;
        r_s1_addr <= io_bus.i_wr_addr;
        r_s1_data <= io_bus.i_wr_data;
        r_s1_old  <= w_wr_old;
      end

      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (io_bus.i_clear) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign io_bus.o_busy     = r_busy;
  assign io_bus.o_rd_valid = r_rd_valid;
  assign io_bus.o_rd_data  = r_rd_data;
  assign io_bus.o_updated  = r_updated;

endmodule

// File: tb/tb_qmax_table_rmw.sv
// -----------------------------------------------------------------------------
// tb_qmax_table_rmw
// Two table instances: 64 entries signed (INIT 0x0005) and 40 entries unsigned
// (INIT 0x00A5). A reference memory model produces expected read data and
// o_updated pulses, queued at drive time and compared as the outputs appear.
// -----------------------------------------------------------------------------
module tb_qmax_table_rmw;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] INIT64 = 16'h0005;
  localparam logic [DW-1:0] INIT40 = 16'h00A5;

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst64_n = 1'b1;
  logic rst40_n = 1'b1;

  always #5 clk = ~clk;

  qmax_table_rmw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if64 ();
  qmax_table_rmw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if40 ();

  qmax_table_rmw #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .SIGNED(1'b1), .INIT_VAL(INIT64)
  ) u_dut64 (
    .i_clk  (clk),
    .i_rst_n(rst64_n),
    .io_bus (if64)
  );

  qmax_table_rmw #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(40), .SIGNED(1'b0), .INIT_VAL(INIT40)
  ) u_dut40 (
    .i_clk  (clk),
    .i_rst_n(rst40_n),
    .io_bus (if40)
  );

  int            errors = 0;
  int            checks = 0;
  rd_exp_t       rd_q[$];
  bit            upd_q[$];
  logic [DW-1:0] model [64];
  int unsigned   cur_depth = 64;
  logic [DW-1:0] cur_init  = INIT64;
  bit            cur_signed = 1'b1;
  logic [DW-1:0] last_data = '0;

  task automatic drive(input bit sel, input bit clr, input bit rd, input logic [AW-1:0] ra,
                       input bit wr, input bit md, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
    if (sel) begin
      if40.i_clear = clr; if40.i_rd_en = rd; if40.i_rd_addr = ra;
      if40.i_wr_en = wr; if40.i_wr_mode = md; if40.i_wr_addr = wa; if40.i_wr_data = wd;
    end else begin
      if64.i_clear = clr; if64.i_rd_en = rd; if64.i_rd_addr = ra;
      if64.i_wr_en = wr; if64.i_wr_mode = md; if64.i_wr_addr = wa; if64.i_wr_data = wd;
    end
  endtask

  task automatic sample(input bit sel, output logic busy, output logic rv,
                        output logic [DW-1:0] rdat, output logic upd);
    if (sel) begin
      busy = if40.o_busy; rv = if40.o_rd_valid; rdat = if40.o_rd_data; upd = if40.o_updated;
    end else begin
      busy = if64.o_busy; rv = if64.o_rd_valid; rdat = if64.o_rd_data; upd = if64.o_updated;
    end
  endtask

  task automatic set_dut(input bit sel);
    cur_depth  = sel ? 40 : 64;
    cur_init   = sel ? INIT40 : INIT64;
    cur_signed = !sel;
  endtask

  // One clock of stimulus: predict, queue expectations, advance, compare
  task automatic step(input bit sel, input bit clr, input bit rd, input logic [AW-1:0] ra,
                      input bit wr, input bit md, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd);
    rd_exp_t       e;
    rd_exp_t       g;
    bit            ue;
    bit            gu;
    bit            cm;
    logic [DW-1:0] old;
    logic          busy, rv, upd;
    logic [DW-1:0] rdat;
    drive(sel, clr, rd, ra, wr, md, wa, wd);
    e.valid = rd && !clr;
    if (e.valid) last_data = (32'(ra) < cur_depth) ? model[ra] : cur_init;
    e.data = last_data;
    // A clear request drops the write sitting in S1
    if (clr && upd_q.size() > 0) upd_q[upd_q.size()-1] = 1'b0;
    ue = 1'b0;
    if (wr && !clr && (32'(wa) < cur_depth)) begin
      old = model[wa];
      cm  = !md || (cur_signed ? ($signed(wd) > $signed(old)) : (wd > old));
      ue  = cm && (wd != old);
      if (cm) model[wa] = wd;
    end
    rd_q.push_back(e);
    upd_q.push_back(ue);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    sample(sel, busy, rv, rdat, upd);
    g  = rd_q.pop_front();
    gu = upd_q.pop_front();
    checks++;
    if (rv !== g.valid) begin
      errors++; $display("FAIL rd_valid dut%0d t=%0t got %b exp %b", sel, $time, rv, g.valid);
    end
    checks++;
    if (rdat !== g.data) begin
      errors++; $display("FAIL rd_data dut%0d t=%0t got %h exp %h", sel, $time, rdat, g.data);
    end
    checks++;
    if (upd !== gu) begin
      errors++; $display("FAIL updated dut%0d t=%0t got %b exp %b", sel, $time, upd, gu);
    end
    checks++;
    if (busy !== clr) begin
      errors++; $display("FAIL busy dut%0d t=%0t got %b exp %b", sel, $time, busy, clr);
    end
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) step(sel, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Count cycles until o_busy falls while hammering the (ignored) ports
  task automatic wait_clear(input bit sel, input int exp_len);
    int            n;
    logic          busy, rv, upd;
    logic [DW-1:0] rdat;
    n    = 0;
    busy = 1'b1;
    while (busy === 1'b1 && n < 300) begin
      drive(sel, 1'b0, 1'b1, '0, 1'b1, 1'b0, '0, 16'h7777);
      @(posedge clk);
      #1;
      n++;
      sample(sel, busy, rv, rdat, upd);
      checks++;
      if (rv !== 1'b0 || upd !== 1'b0 || rdat !== last_data) begin
        errors++;
        $display("FAIL clear_quiet dut%0d t=%0t got rv=%b upd=%b data=%h exp 0 0 %h",
                 sel, $time, rv, upd, rdat, last_data);
      end
    end
    drive(sel, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (busy !== 1'b0 || n != exp_len) begin
      errors++;
      $display("FAIL clear_len dut%0d got %0d cycles busy=%b exp %0d cycles", sel, n, busy, exp_len);
    end
    for (int i = 0; i < 64; i++) model[i] = cur_init;
    rd_q.delete();
    upd_q.delete();
    upd_q.push_back(1'b0);
  endtask

  task automatic check_reset_outs(input bit sel);
    logic          busy, rv, upd;
    logic [DW-1:0] rdat;
    sample(sel, busy, rv, rdat, upd);
    checks++;
    if (busy !== 1'b1 || rv !== 1'b0 || rdat !== '0 || upd !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs dut%0d got busy=%b rv=%b data=%h upd=%b exp 1 0 0000 0",
               sel, busy, rv, rdat, upd);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    #2;
    rst64_n = 1'b0;
    rst40_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs(1'b0);
    check_reset_outs(1'b1);
    set_dut(1'b0);
    last_data = '0;
    rst64_n = 1'b1;
    wait_clear(1'b0, 64);
  endtask

  task automatic test_init_reads();
    step(1'b0, 1'b0, 1'b1, 6'd0,  1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 6'd37, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0, '0, '0);
    idle(1'b0, 1);
  endtask

  task automatic test_overwrite();
    step(1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 1'b0, 6'd3, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, '0, '0);
    idle(1'b0, 2);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 6'd3, 16'h1234);
    idle(1'b0, 2);
  endtask

  task automatic test_max_update();
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 6'd5, 16'h0010);
    idle(1'b0, 1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 6'd5, 16'hFFF0);
    idle(1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 6'd5, 16'h0020);
    idle(1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 6'd5, 16'h0020);
    idle(1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 1'b1, 6'd9, 1'b1, 1'b1, 6'd9, 16'h0030);
    step(1'b0, 1'b0, 1'b1, 6'd9, 1'b1, 1'b1, 6'd9, 16'h0025);
    step(1'b0, 1'b0, 1'b1, 6'd9, 1'b1, 1'b1, 6'd9, 16'h0040);
    step(1'b0, 1'b0, 1'b1, 6'd9, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 6'd9, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 5)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 5)),
           16'($urandom_range(0, 15)) - 16'd6);
    end
    idle(1'b0, 2);
  endtask

  task automatic test_clear();
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 6'd12, 16'h0100);
    step(1'b0, 1'b1, 1'b1, 6'd12, 1'b1, 1'b0, 6'd13, 16'h0200);
    wait_clear(1'b0, 64);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b1, 6'(i), 1'b0, 1'b0, '0, '0);
    idle(1'b0, 1);
  endtask

  task automatic test_dut40();
    set_dut(1'b1);
    last_data = '0;
    rst40_n = 1'b1;
    wait_clear(1'b1, 40);
    step(1'b1, 1'b0, 1'b1, 6'd45, 1'b1, 1'b0, 6'd45, 16'h1111);
    idle(1'b1, 2);
    step(1'b1, 1'b0, 1'b1, 6'd45, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 6'd39, 1'b1, 1'b1, 6'd39, 16'hFFF0);
    step(1'b1, 1'b0, 1'b1, 6'd39, 1'b1, 1'b1, 6'd39, 16'h0010);
    idle(1'b1, 2);
    step(1'b1, 1'b0, 1'b1, 6'd39, 1'b1, 1'b0, 6'd40, 16'h2222);
    idle(1'b1, 2);
    step(1'b1, 1'b0, 1'b1, 6'd40, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_midclear();
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 6'd0, 16'h2222);
    idle(1'b1, 1);
    step(1'b1, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd1, 16'h3333);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (10) @(posedge clk);
    #1;
    rst40_n = 1'b0;
    #1;
    check_reset_outs(1'b1);
    last_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst40_n = 1'b1;
    wait_clear(1'b1, 40);
    step(1'b1, 1'b0, 1'b1, 6'd0,  1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 6'd1,  1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 6'd39, 1'b0, 1'b0, '0, '0);
    idle(1'b1, 1);
  endtask

  initial begin
    test_reset();
    test_init_reads();
    test_overwrite();
    test_max_update();
    test_back_to_back();
    test_clear();
    test_dut40();
    test_reset_midclear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish by t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qmax_table_rmw.md
# qmax_table_rmw

Parametrised Q-max storage block for the Q-learning datapath. It holds one max-Q value per state in single-clock BRAM. It offers a 1-cycle read port and a pipelined write port with two modes: plain overwrite, and max-update (read-modify-write that commits only when the new value is larger). It also performs a self-timed sequential clear after reset or on request, so the surrounding Q-update pipeline never has to clear memory itself.

## Interface
Parameters:
- ADDR_WIDTH, 6, state-address width
- DATA_WIDTH, 16, Q-value width
- DEPTH, 64, number of entries (≤ 2^ADDR_WIDTH; need not be a power of two)
- SIGNED, 1, 1 = two's-complement compare in max-update, 0 = unsigned
- INIT_VAL, 0, value written to every entry by clear; DATA_WIDTH bits

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_clear  in  1  request sequential clear (sampled only in RUN)
- o_busy  out  1  high while clearing; port requests are ignored
- i_rd_en  in  1  read request
- i_rd_addr  in  ADDR_WIDTH  read address
- o_rd_valid  out  1  read data valid (one-cycle pulse per request)
- o_rd_data  out  DATA_WIDTH  read data
- i_wr_en  in  1  write request
- i_wr_mode  in  1  0 = overwrite, 1 = max-update
- i_wr_addr  in  ADDR_WIDTH  write address
- i_wr_data  in  DATA_WIDTH  write data
- o_updated  out  1  pulse: the write in stage S1 changed the entry

## Operation
- Reset is asynchronous and active-low. Reset values: state = CLEAR, clear counter = 0, S1 valid = 0, o_busy = 1, o_rd_valid = 0, o_rd_data = 0, o_updated = 0.
- Memory contents are not reset asynchronously. The CLEAR sweep initialises them.
- FSM state CLEAR:
  - Each cycle, write INIT_VAL to mem[cnt] and increment cnt.
  - When cnt == DEPTH-1, write the last entry and go to RUN.
  - CLEAR lasts exactly DEPTH cycles. o_busy = 1 throughout.
  - i_rd_en and i_wr_en are ignored; no o_rd_valid is produced.
- FSM state RUN:
  - o_busy = 0.
  - If i_clear = 1, go to CLEAR with cnt = 0. S1 is flushed (its pending write is dropped) and the same cycle's port requests are ignored.
- Write pipeline (all writes, both modes):
  - Accept cycle t: capture addr, data and mode into S1. Capture the old value, which is mem[addr], or the forwarded S1 effective value if the current S1 has the same address.
  - Cycle t+1 (S1): compute the effective value.
    - Mode 0: effective = data, commit = 1.
    - Mode 1: commit = (data > old), using the SIGNED compare. Effective = commit ? data : old.
  - If commit, mem[addr] is written at the end of t+1.
  - o_updated = 1 in t+2 iff commit and data ≠ old. A mode-0 write of an equal value does not pulse.
  - A new write may be accepted every cycle. Back-to-back writes to the same address chain correctly through forwarding.
- Read port:
  - Request at t gives o_rd_valid = 1 and o_rd_data at t+1.
  - Data = the S1 effective value if S1 is valid at t with the same address; otherwise mem[addr] as of t.
  - A write accepted in the same cycle t is not visible (read-before-write). It becomes visible to reads issued at t+1 and later.
- Out of range (addr ≥ DEPTH):
  - Writes are dropped and o_updated stays 0.
  - Reads return INIT_VAL with o_rd_valid = 1.
- o_rd_data holds its last value when there is no read.
- Simultaneous read and write, including the same address, are always legal.

## Timing
- Clear duration: DEPTH cycles after i_rst_n rises, and DEPTH cycles after an accepted i_clear. o_busy falls in the cycle the FSM enters RUN.
- Read latency: 1 cycle. Throughput: 1 read and 1 write per cycle.
- Write commit: end of the cycle after acceptance. Memory-visible to reads issued 2 cycles after acceptance; forwarding-visible 1 cycle after.
- o_updated: 2 cycles after write acceptance, 1-cycle pulse.
- Reset asserted mid-clear or mid-write: all control outputs return to their reset values immediately. The clear restarts from entry 0 after deassertion, and any in-flight S1 write is lost.

## Test plan
- Reset, DEPTH=64, INIT_VAL=0x0005 -> o_busy high for 64 cycles. Then reads of addr 0, 37 and 63 return 0x0005 with o_rd_valid one cycle after each request.
- Overwrite 0x1234 to addr 3 at t. Read addr 3 at t, t+1 and t+2 -> old value, then 0x1234, then 0x1234. o_updated pulses at t+2.
- Max-update, SIGNED=1, entry = 0x0010:
  - Write 0xFFF0 (−16) -> no change, o_updated 0.
  - Write 0x0020 -> entry 0x0020, o_updated 1.
  - Write 0x0020 again -> o_updated 0.
- Back-to-back max-updates to addr 9 with 0x0030, 0x0025, 0x0040 on consecutive cycles -> final value 0x0040. o_updated sequence 1, 0, 1. A read issued each cycle shows the forwarded values.
- Assert i_clear in RUN while a write is in S1 -> write dropped, o_busy high for DEPTH cycles, all entries = INIT_VAL afterward.
- DEPTH=40, ADDR_WIDTH=6: write to addr 45 -> dropped, o_updated 0. Read addr 45 -> INIT_VAL. Drop i_rst_n mid-clear -> outputs at reset values, clear restarts at 0.
